// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: occupancy states,
// control-field bit positions and per-stage bundle widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        MAIN  = 2'd1,
        BOTH  = 2'd2
    } pipe_state_e;

    // ID/EX control bundle bit positions
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_ALUSRC   = 4;
    localparam int CTRL_ALUOP_LO = 5;
    localparam int CTRL_ALUOP_HI = 6;
    localparam int CTRL_REGDST   = 7;
    localparam int CTRL_SYS_EN   = 8;

    localparam int IF_ID_CTRL_W  = 1;
    localparam int IF_ID_DATA_W  = 64;
    localparam int ID_EX_CTRL_W  = 9;
    localparam int ID_EX_DATA_W  = 114;
    localparam int EX_MEM_CTRL_W = 5;
    localparam int EX_MEM_DATA_W = 69;
    localparam int MEM_WB_CTRL_W = 3;
    localparam int MEM_WB_DATA_W = 69;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of a pipeline register: control and data bundles loaded
// together on an enable, cleared by the asynchronous reset.
module pipe_slot #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 121
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_ctrl <= '0;
            q_data <= '0;
        end else if (load) begin
            q_ctrl <= d_ctrl;
            q_data <= d_data;
        end
    end

endmodule

// File: rtl/stage_pipe_reg.sv
// Parametrised valid/ready pipeline register with optional 2-entry skid buffer,
// flush and bubble gating of the control bundle.
module stage_pipe_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 121,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [CTRL_W-1:0] up_ctrl,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [CTRL_W-1:0] dn_ctrl,
    output logic [DATA_W-1:0] dn_data,
    output logic [1:0]        occ
);

    pipe_state_e       state_q, state_d;
    logic              in_xfer, out_xfer;
    logic              load_main, load_skid, main_from_skid;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
    logic [DATA_W-1:0] main_data, skid_data, main_d_data;

    assign in_xfer  = up_valid & up_ready;
    assign out_xfer = (state_q != EMPTY) & dn_ready;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d   = MAIN;
                        load_main = 1'b1;
                    end
                end
                MAIN: begin
                    if (in_xfer && out_xfer) begin
                        load_main = 1'b1;
                    end else if (in_xfer && (SKID != 0)) begin
                        state_d   = BOTH;
                        load_skid = 1'b1;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                BOTH: begin
                    if (out_xfer) begin
                        state_d        = MAIN;
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    assign main_d_ctrl = main_from_skid ? skid_ctrl : up_ctrl;
    assign main_d_data = main_from_skid ? skid_data : up_data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load_main),
        .d_ctrl (main_d_ctrl),
        .d_data (main_d_data),
        .q_ctrl (main_ctrl),
        .q_data (main_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic up_ready_q;

            pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clk    (clk),
                .rst_n  (rst_n),
                .load   (load_skid),
                .d_ctrl (up_ctrl),
                .d_data (up_data),
                .q_ctrl (skid_ctrl),
                .q_data (skid_data)
            );

            // Registered ready: no combinational path from dn_ready upstream
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) up_ready_q <= 1'b0;
                else        up_ready_q <= (state_d != BOTH);
            end
            assign up_ready = up_ready_q;
        end else begin : g_single
            logic rst_done_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) rst_done_q <= 1'b0;
                else        rst_done_q <= 1'b1;
            end
            assign skid_ctrl = '0;
            assign skid_data = '0;
            assign up_ready  = rst_done_q & ((state_q == EMPTY) | dn_ready);
        end
    endgenerate

    // Bubbles are gated at the output so a stale stored control never fires
    assign dn_valid = (state_q != EMPTY);
    assign dn_ctrl  = dn_valid ? main_ctrl : '0;
    assign dn_data  = main_data;
    assign occ      = state_q;

endmodule

// File: tb/tb_stage_pipe_reg.sv
// Self-checking bench: SKID=1 and SKID=0 instances against queue-based reference models.
module tb_stage_pipe_reg;

    localparam int CW = 9;
    localparam int DW = 32;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } entry_t;

    logic          clk = 1'b0;
    logic          rst_n, flush, up_valid;
    logic [CW-1:0] up_ctrl;
    logic [DW-1:0] up_data;
    logic          dn_ready1, dn_ready0;
    logic          up_ready1, dn_valid1, up_ready0, dn_valid0;
    logic [CW-1:0] dn_ctrl1, dn_ctrl0;
    logic [DW-1:0] dn_data1, dn_data0;
    logic [1:0]    occ1, occ0;

    int     total = 0;
    int     bad = 0;
    bit     compare_en = 1'b0;
    entry_t q1[$];
    entry_t q0[$];
    bit     m_rdy1, m_rst_done0;

    always #5 clk = ~clk;

    stage_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .up_valid(up_valid), .up_ready(up_ready1), .up_ctrl(up_ctrl), .up_data(up_data),
        .dn_valid(dn_valid1), .dn_ready(dn_ready1), .dn_ctrl(dn_ctrl1), .dn_data(dn_data1),
        .occ(occ1)
    );

    stage_pipe_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .up_valid(up_valid), .up_ready(up_ready0), .up_ctrl(up_ctrl), .up_data(up_data),
        .dn_valid(dn_valid0), .dn_ready(dn_ready0), .dn_ctrl(dn_ctrl0), .dn_data(dn_data0),
        .occ(occ0)
    );

    function automatic bit m_up_ready0();
        return m_rst_done0 && ((q0.size() == 0) || dn_ready0);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                                 input bit r1, input bit fl);
        up_valid  = v;
        up_ctrl   = c;
        up_data   = d;
        dn_ready1 = r1;
        dn_ready0 = ~dn_ready0;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    // Reference model: FIFO queues of held entries, capacity 2 (skid) or 1 (single)
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1.delete();
            q0.delete();
            m_rdy1      = 1'b0;
            m_rst_done0 = 1'b0;
        end else begin
            bit in1, out1, in0, out0;
            in1  = up_valid && m_rdy1;
            out1 = (q1.size() > 0) && dn_ready1;
            in0  = up_valid && m_up_ready0();
            out0 = (q0.size() > 0) && dn_ready0;
            if (flush) q1.delete();
            else begin
                if (out1) void'(q1.pop_front());
                if (in1) q1.push_back({up_ctrl, up_data});
            end
            if (flush) q0.delete();
            else begin
                if (out0) void'(q0.pop_front());
                if (in0) q0.push_back({up_ctrl, up_data});
            end
            m_rdy1      = (q1.size() < 2);
            m_rst_done0 = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (compare_en && rst_n) begin
            checkOutput("s1_valid", dn_valid1, q1.size() > 0);
            checkOutput("s1_occ", occ1, q1.size());
            checkOutput("s1_up_ready", up_ready1, m_rdy1);
            if (q1.size() > 0) begin
                checkOutput("s1_ctrl", dn_ctrl1, q1[0].c);
                checkOutput("s1_data", dn_data1, q1[0].d);
            end else begin
                checkOutput("s1_bubble_ctrl", dn_ctrl1, 0);
            end
            checkOutput("s0_valid", dn_valid0, q0.size() > 0);
            checkOutput("s0_occ", occ0, q0.size());
            checkOutput("s0_up_ready", up_ready0, m_up_ready0());
            if (q0.size() > 0) begin
                checkOutput("s0_ctrl", dn_ctrl0, q0[0].c);
                checkOutput("s0_data", dn_data0, q0[0].d);
            end else begin
                checkOutput("s0_bubble_ctrl", dn_ctrl0, 0);
            end
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; up_valid = 1'b0; up_ctrl = '0; up_data = '0;
        dn_ready1 = 1'b0; dn_ready0 = 1'b0;
        #12;
        checkOutput("rst_valid", dn_valid1, 0);
        checkOutput("rst_occ", occ1, 0);
        checkOutput("rst_data", dn_data1, 0);
        checkOutput("rst_up_ready", up_ready1, 0);
        checkOutput("rst_up_ready0", up_ready0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rdy_before_clk", up_ready1, 0);
        @(posedge clk);
        #1;
        checkOutput("rdy_after_release", up_ready1, 1);
        compare_en = 1'b1;

        // Back-to-back streaming, one-cycle latency
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 9'h012, DW'(i), 1'b1, 1'b0);
            checkOutput("stream_valid", dn_valid1, 1);
            checkOutput("stream_data", dn_data1, i);
            checkOutput("stream_ready", up_ready1, 1);
        end
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("stream_drained", dn_valid1, 0);

        // Stall with A,B,C offered, then release
        applyStimulus(1'b1, 9'h003, 32'hA, 1'b0, 1'b0);
        checkOutput("stall1_occ", occ1, 1);
        checkOutput("stall1_data", dn_data1, 32'hA);
        checkOutput("stall1_ready", up_ready1, 1);
        applyStimulus(1'b1, 9'h003, 32'hB, 1'b0, 1'b0);
        checkOutput("stall2_occ", occ1, 2);
        checkOutput("stall2_ready", up_ready1, 0);
        checkOutput("stall2_data", dn_data1, 32'hA);
        applyStimulus(1'b1, 9'h003, 32'hC, 1'b0, 1'b0);
        checkOutput("stall3_occ", occ1, 2);
        checkOutput("stall3_ready", up_ready1, 0);
        applyStimulus(1'b1, 9'h003, 32'hC, 1'b1, 1'b0);
        checkOutput("release1_data", dn_data1, 32'hB);
        checkOutput("release1_occ", occ1, 1);
        checkOutput("release1_ready", up_ready1, 1);
        applyStimulus(1'b1, 9'h003, 32'hC, 1'b1, 1'b0);
        checkOutput("release2_data", dn_data1, 32'hC);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("release3_occ", occ1, 0);

        // Flush while BOTH, X offered in flush cycle
        applyStimulus(1'b1, 9'h1F0, 32'h111, 1'b0, 1'b0);
        applyStimulus(1'b1, 9'h1F0, 32'h222, 1'b0, 1'b0);
        checkOutput("pre_flush_occ", occ1, 2);
        applyStimulus(1'b1, 9'h1F0, 32'hBAD, 1'b0, 1'b1);
        checkOutput("flush_valid", dn_valid1, 0);
        checkOutput("flush_ctrl", dn_ctrl1, 0);
        checkOutput("flush_occ", occ1, 0);
        checkOutput("flush_ready", up_ready1, 1);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("post_flush_valid", dn_valid1, 0);

        // Bubbles between all-ones control entries
        for (int i = 0; i < 8; i++) begin
            applyStimulus((i % 2) == 0, 9'h1FF, DW'(100 + i), 1'b1, 1'b0);
            checkOutput("bubble_valid", dn_valid1, (i % 2) == 0);
            checkOutput("bubble_ctrl", dn_ctrl1, ((i % 2) == 0) ? 9'h1FF : 9'h000);
        end

        // Asynchronous reset with two entries held
        applyStimulus(1'b1, 9'h055, 32'h31, 1'b0, 1'b0);
        applyStimulus(1'b1, 9'h055, 32'h32, 1'b0, 1'b0);
        checkOutput("prerst_occ", occ1, 2);
        up_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", dn_valid1, 0);
        checkOutput("midrst_ctrl", dn_ctrl1, 0);
        checkOutput("midrst_occ", occ1, 0);
        checkOutput("midrst_ready", up_ready1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("postrst_ready", up_ready1, 1);

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), CW'($urandom), DW'($urandom),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        compare_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
